// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data,
// full/empty flags and a rejected-request pulse.
module sync_fifo #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             error_o
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                  full, empty;
  logic                  wr_ok, rd_ok;

  assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

  // MSB is the wrap toggle: equal lows with
  // differing MSBs means one full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  =
    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
    (wr_idx == rd_idx);

  assign wr_ok = wr_en_i & ~full;
  assign rd_ok = rd_en_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_idx];
    end
    error_d = (wr_en_i & full) | (rd_en_i & empty);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_idx] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign error_o = error_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: vector table plus
// queue scoreboard over fill/drain/wrap/reset.
module tb_sync_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] wdata_i = '0;
  logic [3:0] rdata_o;
  logic       wr_en_i = 1'b0;
  logic       rd_en_i = 1'b0;
  logic       full_o, empty_o, error_o;

  sync_fifo #(.WIDTH(4), .DEPTH(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .wr_en_i (wr_en_i),
    .rd_en_i (rd_en_i),
    .full_o  (full_o),
    .empty_o (empty_o),
    .error_o (error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] sb [$];
  logic [3:0] exp_rdata = '0;
  logic       exp_err   = 1'b0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] d;
    logic       e_empty;
    logic       e_full;
    logic       e_err;
    logic [3:0] e_rd;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name,
                       input int act,
                       input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  // One clock of stimulus; model predicts from
  // pre-edge occupancy, then all outputs checked.
  task automatic cycle(input logic wr,
                       input logic rd,
                       input logic [3:0] d,
                       input string tag);
    logic m_full, m_empty;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == 16);
    exp_err = (wr & m_full) | (rd & m_empty);
    if (rd && !m_empty) exp_rdata = sb.pop_front();
    if (wr && !m_full) sb.push_back(d);
    wr_en_i = wr;
    rd_en_i = rd;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    check({tag, "_err"},   int'(error_o), int'(exp_err));
    check({tag, "_rdata"}, int'(rdata_o), int'(exp_rdata));
    check({tag, "_empty"}, int'(empty_o),
          int'(sb.size() == 0));
    check({tag, "_full"},  int'(full_o),
          int'(sb.size() == 16));
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5};
    tbl[4] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 4'h3};
    tbl[5] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h9};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h9};
    tbl[7] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 4'h9};
    tbl[8] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7};

    // reset held over two edges
    model_reset();
    repeat (2) begin
      @(posedge clk_i);
      #1;
      check("rst_empty", int'(empty_o), 1);
      check("rst_full",  int'(full_o),  0);
      check("rst_err",   int'(error_o), 0);
      check("rst_rdata", int'(rdata_o), 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle(1'b0, 1'b0, 4'h0, "idle");

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].d,
            $sformatf("tbsb%0d", i));
      check($sformatf("tbl%0d_empty", i),
            int'(empty_o), int'(tbl[i].e_empty));
      check($sformatf("tbl%0d_full", i),
            int'(full_o), int'(tbl[i].e_full));
      check($sformatf("tbl%0d_err", i),
            int'(error_o), int'(tbl[i].e_err));
      check($sformatf("tbl%0d_rdata", i),
            int'(rdata_o), int'(tbl[i].e_rd));
    end

    // fill, overflow, drain, underflow
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b0, 4'($urandom), "fill");
    check("fill_full", int'(full_o), 1);
    cycle(1'b1, 1'b0, 4'hA, "ovf");
    check("ovf_err", int'(error_o), 1);
    cycle(1'b0, 1'b0, 4'h0, "ovf_idle");
    check("ovf_clear", int'(error_o), 0);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b1, 4'h0, "drain");
    check("drain_empty", int'(empty_o), 1);
    cycle(1'b0, 1'b1, 4'h0, "udf");
    check("udf_err", int'(error_o), 1);
    cycle(1'b0, 0, 4'h0, "udf_idle");

    // wrap and concurrent traffic
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b0, 4'($urandom), "wr10");
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 4'h0, "rd10");
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b0, 4'($urandom), "pre8");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 4'($urandom), "conc");
      check("conc_occ", sb.size(), 8);
    end

    // reset in the middle of traffic
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check("mrst_empty", int'(empty_o), 1);
    check("mrst_full",  int'(full_o),  0);
    check("mrst_rdata", int'(rdata_o), 0);
    check("mrst_err",   int'(error_o), 0);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle(1'b1, 1'b0, 4'hC, "post_wr");
    cycle(1'b0, 1'b1, 4'h0, "post_rd");
    check("post_rdata", int'(rdata_o), 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in-first-out buffer of DEPTH entries, each WIDTH bits wide. It sits between a producer and a consumer in the same clock domain. It provides registered read data, full and empty status flags, and an error pulse when a write overflows or a read underflows.

Parameters:
WIDTH, 4, data word width in bits.
DEPTH, 16, number of storage entries; must be a power of two and at least 2.
ADDR_WIDTH, $clog2(DEPTH), storage index width; derived, not to be overridden.

Ports:
clk_i  input  1  single clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-low reset.
wdata_i  input  WIDTH  write data.
rdata_o  output  WIDTH  registered read data.
wr_en_i  input  1  write request.
rd_en_i  input  1  read request.
full_o  output  1  FIFO holds DEPTH entries.
empty_o  output  1  FIFO holds 0 entries.
error_o  output  1  registered pulse flagging a rejected write or read.

Behaviour:
- Interface decisions (already decided): one clock, clk_i. Reset rst_i is asynchronous and active-low.
- Port order in the module header: clk_i, rst_i, wdata_i, rdata_o, wr_en_i, rd_en_i, full_o, empty_o, error_o.
- Reset (rst_i=0, takes effect immediately without a clock edge):
  - write pointer = 0, read pointer = 0;
  - rdata_o = 0, error_o = 0, empty_o = 1, full_o = 0;
  - storage contents are don't-care after reset.
- Pointers: wr_ptr and rd_ptr are each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index storage; the MSB is a wrap toggle.
- Flags (combinational from the pointers):
  - empty_o = (wr_ptr == rd_ptr);
  - full_o = (MSBs differ) and (low bits equal).
- Write: at a rising edge with wr_en_i=1 and full_o=0:
  - mem[wr_ptr low bits] <= wdata_i;
  - wr_ptr increments, wrapping naturally modulo 2*DEPTH.
- Read: at a rising edge with rd_en_i=1 and empty_o=0:
  - rdata_o <= mem[rd_ptr low bits], so data is valid one edge after the request;
  - rd_ptr increments.
- rdata_o holds its last value whenever no read is accepted.
- Flags are evaluated from the state before the edge:
  - a write while full is dropped, even if a read is accepted in the same cycle;
  - a read while empty is dropped, even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance, occupancy is unchanged, and the flags stay the same.
- error_o is registered: at each edge, error_o <= (wr_en_i & full_o) | (rd_en_i & empty_o). It therefore pulses high for each cycle in which a request was rejected, is not sticky, and has no effect on the pointers.
- Ordering: data is returned strictly in write order, including across pointer wrap-around.
- Reset mid-operation: all data is discarded immediately, and the flags return to empty.

Test Plan:
- Reset check: hold rst_i=0 for 2 edges -> empty_o=1, full_o=0, error_o=0, rdata_o=0 during reset. These values persist after release while no requests are made.
- Fill: write 16 random values on 16 consecutive edges -> empty_o drops after the first write; full_o=1 after the 16th write; error_o stays 0.
- Overflow: one extra write of 4'hA while full -> error_o=1 for one cycle after the edge; full_o stays 1; the pointers do not move.
- Drain: 16 consecutive reads -> rdata_o returns the 16 written values in order, each one edge after its request; empty_o=1 after the last read.
- Underflow: a read while empty -> error_o=1 for one cycle; rdata_o keeps the last value.
- Wrap and concurrency: write 10 entries and read 10, then with 8 entries stored, assert wr_en_i and rd_en_i together for 20 cycles -> occupancy stays 8, data stays in order across the pointer wrap, error_o=0. Also assert rst_i=0 mid-stream -> empty_o=1 immediately.
